// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, captures the combinational memory word and
// buffers {instr, pc} pairs in a small FIFO toward decode; handles redirect, halt and misalignment.
module instr_fetch_unit #(
  parameter int unsigned              ADDR_WIDTH = 10,
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] ProgCounter,
  input  logic [DATA_WIDTH-1:0] InstrIn,
  output logic [DATA_WIDTH-1:0] InstrOut,
  output logic [ADDR_WIDTH-1:0] InstrPC,
  output logic                  InstrValid,
  input  logic                  InstrReady,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] RedirectTarget,
  input  logic                  Halt,
  output logic                  MisalignFault
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          count;
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0]  buf_instr [DEPTH];
  logic [ADDR_WIDTH-1:0]  buf_pc    [DEPTH];

  logic                   pop, push, flush, fault_next;
  logic [ADDR_WIDTH-1:0]  pc_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign InstrValid = (count != '0);
  assign InstrOut   = buf_instr[rd_ptr];
  assign InstrPC    = buf_pc[rd_ptr];
  assign pop        = InstrValid & InstrReady;

  // Halt outranks Redirect; a push is allowed into a full buffer only when a pop frees a slot.
  always_comb begin
    push       = 1'b0;
    flush      = 1'b0;
    pc_next    = ProgCounter;
    state_next = state;
    fault_next = MisalignFault;
    case (state)
      RUN, HALTED: begin
        if (Halt) begin
          state_next = HALTED;
        end else if (Redirect) begin
          flush = 1'b1;
          if (RedirectTarget[1:0] != 2'b00) begin
            fault_next = 1'b1;
            state_next = FAULT;
          end else begin
            pc_next    = RedirectTarget;
            state_next = RUN;
          end
        end else if (state == RUN && ((count < CW'(DEPTH)) || pop)) begin
          push    = 1'b1;
          pc_next = ProgCounter + ADDR_WIDTH'(4);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      ProgCounter   <= RESET_PC;
      MisalignFault <= 1'b0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else begin
      state         <= state_next;
      ProgCounter   <= pc_next;
      MisalignFault <= fault_next;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          buf_instr[wr_ptr] <= InstrIn;
          buf_pc[wr_ptr]    <= ProgCounter;
          wr_ptr            <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory model returns word index (mem[i] = i).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  prog_counter;
  logic [31:0] instr_in;
  logic [31:0] instr_out;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [9:0]  redirect_target;
  logic        halt;
  logic        misalign_fault;

  int tests  = 0;
  int failed = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .DEPTH(2),
    .RESET_PC(10'd0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ProgCounter(prog_counter),
    .InstrIn(instr_in),
    .InstrOut(instr_out),
    .InstrPC(instr_pc),
    .InstrValid(instr_valid),
    .InstrReady(instr_ready),
    .Redirect(redirect),
    .RedirectTarget(redirect_target),
    .Halt(halt),
    .MisalignFault(misalign_fault)
  );

  always #5 clk = ~clk;

  assign instr_in = {24'd0, prog_counter[9:2]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check("rst_pc", 32'(prog_counter), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(misalign_fault), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    redirect_target = '0; halt = 1'b0;

    // 1: streaming, no bubbles
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_out", instr_out, 32'(k));
      check("t1_ipc", 32'(instr_pc), 32'(4 * k));
      check("t1_pc", 32'(prog_counter), 32'(4 * k + 4));
    end

    // 2: backpressure fills exactly two entries, reset discards live buffer
    reset = 1'b1; instr_ready = 1'b0;
    step();
    check("t2_rst_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("t2_pc_stall", 32'(prog_counter), 32'd8);
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_ipc0", 32'(instr_pc), 32'd0);
    check("t2_out0", instr_out, 32'd0);
    instr_ready = 1'b1;
    step();
    check("t2_ipc4", 32'(instr_pc), 32'd4);
    check("t2_out1", instr_out, 32'd1);
    step();
    check("t2_ipc8", 32'(instr_pc), 32'd8);
    check("t2_out2", instr_out, 32'd2);

    // 3: redirect with full buffer and a pop in the same cycle
    reset = 1'b1; instr_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    check("t3_pc_full", 32'(prog_counter), 32'd8);
    instr_ready = 1'b1; redirect = 1'b1; redirect_target = 10'd40;
    check("t3_popped", 32'(instr_pc), 32'd0);
    step();
    redirect = 1'b0;
    check("t3_flush", 32'(instr_valid), 32'd0);
    check("t3_pc40", 32'(prog_counter), 32'd40);
    step();
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_ipc40", 32'(instr_pc), 32'd40);
    check("t3_out10", instr_out, 32'd10);
    step();
    check("t3_ipc44", 32'(instr_pc), 32'd44);

    // 4: PC wraps 1020 -> 0 without fault
    redirect = 1'b1; redirect_target = 10'd1020;
    step();
    redirect = 1'b0;
    check("t4_flush", 32'(instr_valid), 32'd0);
    step();
    check("t4_ipc1020", 32'(instr_pc), 32'd1020);
    check("t4_out255", instr_out, 32'd255);
    check("t4_pc_wrap", 32'(prog_counter), 32'd0);
    step();
    check("t4_ipc0", 32'(instr_pc), 32'd0);
    step();
    check("t4_ipc4", 32'(instr_pc), 32'd4);
    check("t4_nofault", 32'(misalign_fault), 32'd0);

    // 5: halt drains and freezes; halt beats redirect; aligned redirect resumes
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("t5_drain", 32'(instr_valid), 32'd0);
    check("t5_pc_frz", 32'(prog_counter), 32'd8);
    step();
    step();
    check("t5_still_halt", 32'(instr_valid), 32'd0);
    check("t5_pc_frz2", 32'(prog_counter), 32'd8);
    halt = 1'b1; redirect = 1'b1; redirect_target = 10'd100;
    step();
    halt = 1'b0;
    check("t5_hr_ignored", 32'(prog_counter), 32'd8);
    redirect_target = 10'd16;
    step();
    redirect = 1'b0;
    check("t5_pc16", 32'(prog_counter), 32'd16);
    step();
    check("t5_ipc16", 32'(instr_pc), 32'd16);
    check("t5_out4", instr_out, 32'd4);
    check("t5_pc20", 32'(prog_counter), 32'd20);

    // 6: misaligned redirect faults; only reset recovers
    redirect = 1'b1; redirect_target = 10'd42;
    step();
    check("t6_fault", 32'(misalign_fault), 32'd1);
    check("t6_flush", 32'(instr_valid), 32'd0);
    check("t6_pc_hold", 32'(prog_counter), 32'd20);
    redirect_target = 10'd8;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_stuck_valid", 32'(instr_valid), 32'd0);
      check("t6_stuck_pc", 32'(prog_counter), 32'd20);
      check("t6_sticky", 32'(misalign_fault), 32'd1);
    end
    redirect = 1'b0;
    do_reset();
    step();
    check("t6_restart_valid", 32'(instr_valid), 32'd1);
    check("t6_restart_ipc", 32'(instr_pc), 32'd0);
    check("t6_restart_pc", 32'(prog_counter), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
